spike_mac_accum: RTL



---
 rtl/snn_mac_pkg.sv | 62 ++++++
 rtl/spike_masked_adder.sv | 31 +++
 rtl/spike_mac_accum.sv | 124 ++++++++++++
 3 files changed

// File: rtl/snn_mac_pkg.sv
// Shared constants and arithmetic helpers for the
// spike-gated MAC and the neuron membrane update.
package snn_mac_pkg;

  localparam int SNN_NUM_CH   = 4;
  localparam int SNN_WEIGHT_W = 32;
  localparam int SNN_ACC_W    = 32;
  localparam int SNN_CNT_W    = 16;

  // Working width of sat_add; must exceed every operand width.
  localparam int MAXW = 64;

  typedef struct packed {
    logic [MAXW-1:0] val;
    logic            ovf;
  } sat_res_t;

  function automatic int s1_width(
    input int wt_w,
    input int nch
  );
    return wt_w + $clog2(nch) + 1;
  endfunction

  function automatic int pop_width(
    input int nch
  );
    return $clog2(nch + 1);
  endfunction

  // Exact add, then clamp (clamp=1) or wrap (clamp=0) to w bits.
  function automatic sat_res_t sat_add(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b,
    input int                     w,
    input logic                   clamp
  );
    sat_res_t                r;
    logic signed [MAXW-1:0] one;
    logic signed [MAXW-1:0] s;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    logic signed [MAXW-1:0] tr;
    one = 1;
    s   = a + b;
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    tr  = (s <<< (MAXW - w)) >>> (MAXW - w);
    r.ovf = (tr != s);
    if (!clamp) begin
      r.val = tr;
    end else if (s > hi) begin
      r.val = hi;
    end else if (s < lo) begin
      r.val = lo;
    end else begin
      r.val = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_masked_adder.sv
// Combinational spike-masked weight sum and
// spike popcount for one NUM_CH-wide beat.
module spike_masked_adder #(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 32,
  parameter int SW       = 35,
  parameter int PW       = 3
) (
  input  logic [NUM_CH-1:0]          spikes_i,
  input  logic [NUM_CH*WEIGHT_W-1:0] weights_i,
  output logic signed [SW-1:0]       partial_o,
  output logic [PW-1:0]              pop_o
);

  logic [WEIGHT_W-1:0] wk;

  always_comb begin
    partial_o = '0;
    pop_o     = '0;
    wk        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wk = weights_i[k*WEIGHT_W +: WEIGHT_W];
      if (spikes_i[k]) begin
        partial_o = partial_o +
          {{(SW-WEIGHT_W){wk[WEIGHT_W-1]}}, wk};
        pop_o = pop_o + PW'(1);
      end
    end
  end

endmodule

// File: rtl/spike_mac_accum.sv
// Two-stage spike-gated multiply-accumulate:
// per-beat masked sum, then per-packet accumulate.
module spike_mac_accum
  import snn_mac_pkg::*;
#(
  parameter int NUM_CH   = SNN_NUM_CH,
  parameter int WEIGHT_W = SNN_WEIGHT_W,
  parameter int ACC_W    = SNN_ACC_W,
  parameter int CNT_W    = SNN_CNT_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH-1:0]          in_spikes,
  input  logic [NUM_CH*WEIGHT_W-1:0] in_weights,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [CNT_W-1:0]           out_spike_count,
  output logic                       out_sat
);

  localparam int SW = s1_width(WEIGHT_W, NUM_CH);
  localparam int PW = pop_width(NUM_CH);

  logic                    en;
  logic signed [SW-1:0]    part_d;
  logic [PW-1:0]           pop_d;
  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic signed [SW-1:0]    s1_part_q;
  logic [PW-1:0]           s1_pop_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [CNT_W:0]          cnt_sum;
  logic                    sat_q;
  logic                    sat_d;
  logic                    out_valid_q;
  logic [ACC_W-1:0]        out_sum_q;
  logic [CNT_W-1:0]        out_cnt_q;
  logic                    out_sat_q;
  logic [MAXW-1:0]         acc_x;
  logic [MAXW-1:0]         part_x;
  sat_res_t                res;
  logic                    unused_hi;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  spike_masked_adder #(
    .NUM_CH   (NUM_CH),
    .WEIGHT_W (WEIGHT_W),
    .SW       (SW),
    .PW       (PW)
  ) u_adder (
    .spikes_i  (in_spikes),
    .weights_i (in_weights),
    .partial_o (part_d),
    .pop_o     (pop_d)
  );

  assign acc_x  = {{(MAXW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign part_x = {{(MAXW-SW){s1_part_q[SW-1]}}, s1_part_q};

  always_comb begin
    res     = sat_add(acc_x, part_x, ACC_W, SATURATE);
    acc_d   = res.val[ACC_W-1:0];
    sat_d   = sat_q | res.ovf;
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(s1_pop_q);
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  assign unused_hi = ^res.val[MAXW-1:ACC_W];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_part_q   <= '0;
      s1_pop_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_last_q <= in_last;
        s1_part_q <= part_d;
        s1_pop_q  <= pop_d;
      end
      // A new result replaces one being handed off this cycle.
      out_valid_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_sum_q <= acc_d;
          out_cnt_q <= cnt_d;
          out_sat_q <= sat_d;
          acc_q     <= '0;
          cnt_q     <= '0;
          sat_q     <= 1'b0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          sat_q <= sat_d;
        end
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_sum         = out_sum_q;
  assign out_spike_count = out_cnt_q;
  assign out_sat         = out_sat_q;

endmodule
